// File: rtl/ctrl_pkg.sv
// Shared types and constants for the load-multiple / store-multiple sequencer.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } lmsm_state_t;

    localparam logic MODE_LM = 1'b0;
    localparam logic MODE_SM = 1'b1;

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder; purely combinational.
module prio_enc_lsb #(
    parameter int N = 8,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  in_vec,
    output logic [AW-1:0] idx,
    output logic          valid
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx = AW'(i);
            end
        end
        valid = |in_vec;
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple transfer engine: walks the register mask
// lowest-first, one register per memory handshake, then pulses done.
//
//  state | meaning
//  IDLE  | waiting for start; operands latched on accept
//  XFER  | one memory access per set mask bit, held until mem_ready
//  DONE  | one-cycle completion pulse, back to IDLE
module lmsm_sequencer
    import ctrl_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NREGS     = 8,
    parameter int ADDR_W    = 16,
    parameter int ADDR_STEP = 1,
    localparam int REG_AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREGS-1:0]  reg_mask,
    output logic              busy,
    output logic              done,
    output logic [REG_AW:0]   xfer_count,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(ADDR_STEP);
    localparam logic [REG_AW:0]   CNT_ONE  = (REG_AW + 1)'(1);

    lmsm_state_t       state_q, state_d;
    logic [NREGS-1:0]  mask_q, mask_d, mask_clr;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mode_q, mode_d;
    logic [REG_AW:0]   count_q, count_d;
    logic              busy_q, done_q, req_q, we_q;
    logic [REG_AW-1:0] cur_reg;
    logic              cur_valid;

    prio_enc_lsb #(.N(NREGS)) u_prio_enc (
        .in_vec (mask_q),
        .idx    (cur_reg),
        .valid  (cur_valid)
    );

    always_comb begin
        state_d           = state_q;
        mask_d            = mask_q;
        addr_d            = addr_q;
        mode_d            = mode_q;
        count_d           = count_q;
        mask_clr          = mask_q;
        mask_clr[cur_reg] = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    addr_d  = base_addr;
                    mask_d  = reg_mask;
                    count_d = '0;
                    state_d = (reg_mask != '0) ? XFER : DONE;
                end
            end
            XFER: begin
                if (mem_ready && cur_valid) begin
                    mask_d  = mask_clr;
                    addr_d  = addr_q + ADDR_INC;
                    count_d = count_q + CNT_ONE;
                    if (mask_clr == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            mode_q  <= MODE_LM;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            req_q   <= (state_d == XFER);
            we_q    <= (state_d == XFER) && (mode_d == MODE_SM);
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign xfer_count = count_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign rf_raddr   = cur_reg;
    assign rf_waddr   = cur_reg;
    assign mem_wdata  = rf_rdata;
    assign rf_wdata   = mem_rdata;
    assign rf_we      = req_q && mem_ready && (mode_q == MODE_LM);

endmodule
